// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - cpu/dbg requester ports, memory port-2 and status bundle
interface mem_port_arbiter_if;
  logic        cpu_req, dbg_req;
  logic        cpu_we, dbg_we;
  logic [31:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [1:0]  cpu_size, dbg_size;
  logic        cpu_sign, dbg_sign;
  logic        cpu_ack, dbg_ack;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_rden2, mem_we2;
  logic [31:0] mem_addr2, mem_din2;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_dout2;
  logic        busy;
  logic        gnt_id;

  modport slave (
    input  cpu_req, dbg_req, cpu_we, dbg_we, cpu_addr, dbg_addr,
           cpu_wdata, dbg_wdata, cpu_size, dbg_size, cpu_sign, dbg_sign, mem_dout2,
    output cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, mem_rden2, mem_we2,
           mem_addr2, mem_din2, mem_size, mem_sign, busy, gnt_id
  );

  modport master (
    output cpu_req, dbg_req, cpu_we, dbg_we, cpu_addr, dbg_addr,
           cpu_wdata, dbg_wdata, cpu_size, dbg_size, cpu_sign, dbg_sign, mem_dout2,
    input  cpu_ack, dbg_ack, cpu_rdata, dbg_rdata, mem_rden2, mem_we2,
           mem_addr2, mem_din2, mem_size, mem_sign, busy, gnt_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (cpu/dbg) arbiter onto memory port 2
// Optional ARB_ROUND_ROBIN_EN: alternate winners on contention; otherwise cpu has fixed priority.
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        gnt_q, gnt_nxt;
  logic        grant;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        sign_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
          if (bus.cpu_req && bus.dbg_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_nxt = ~last_grant;
`else
            gnt_nxt = 1'b0;
`endif
          end else begin
            gnt_nxt = bus.dbg_req;
          end
        end
      end
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and acks are gated by rst so an interrupted transaction leaves no trace.
  always_comb begin
    bus.mem_rden2 = 1'b0;
    bus.mem_we2   = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.dbg_ack   = 1'b0;
    bus.cpu_rdata = 32'h0;
    bus.dbg_rdata = 32'h0;
    if (!rst) begin
      if (state == ISSUE) begin
        bus.mem_we2   = we_q;
        bus.mem_rden2 = ~we_q;
      end
      if (state == RESP) begin
        bus.cpu_ack = ~gnt_q;
        bus.dbg_ack = gnt_q;
        if (!we_q) begin
          if (gnt_q) bus.dbg_rdata = bus.mem_dout2;
          else       bus.cpu_rdata = bus.mem_dout2;
        end
      end
    end
  end

  // Latched request fields only change on a grant, so they double as the held port values.
  assign bus.mem_addr2 = addr_q;
  assign bus.mem_din2  = wdata_q;
  assign bus.mem_size  = size_q;
  assign bus.mem_sign  = sign_q;
  assign bus.busy      = (state != IDLE);
  assign bus.gnt_id    = gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      if (grant) begin
        we_q    <= gnt_nxt ? bus.dbg_we    : bus.cpu_we;
        addr_q  <= gnt_nxt ? bus.dbg_addr  : bus.cpu_addr;
        wdata_q <= gnt_nxt ? bus.dbg_wdata : bus.cpu_wdata;
        size_q  <= gnt_nxt ? bus.dbg_size  : bus.cpu_size;
        sign_q  <= gnt_nxt ? bus.dbg_sign  : bus.cpu_sign;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant <= gnt_nxt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (honours ARB_ROUND_ROBIN_EN)
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] tb_mem  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] fill_val(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] tb_mem_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : fill_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill_val(a);
  endfunction

  // Memory port-2 responder: read data appears the cycle after mem_rden2.
  always @(posedge clk) begin
    if (bus.mem_we2) tb_mem[bus.mem_addr2] = bus.mem_din2;
    if (bus.mem_rden2) bus.mem_dout2 <= tb_mem_rd(bus.mem_addr2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit who, input bit req, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input bit sign);
    if (who) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr;
      bus.dbg_wdata = wdata; bus.dbg_size = size; bus.dbg_sign = sign;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
      bus.cpu_wdata = wdata; bus.cpu_size = size; bus.cpu_sign = sign;
    end
  endtask

  task automatic clear_inputs();
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_txn(input bit who, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input bit sign, input logic [31:0] addr_late,
                        input logic [31:0] exp_rd, input string tag);
    @(negedge clk);
    drive_req(who, 1'b1, we, addr, wdata, size, sign);
    #2;
    check({tag, "_idle_busy"}, bus.busy, 0);
    @(negedge clk);
    drive_req(who, 1'b1, we, addr_late, wdata, size, sign);
    #2;
    check({tag, "_we2"}, bus.mem_we2, we);
    check({tag, "_rden2"}, bus.mem_rden2, !we);
    check({tag, "_addr2"}, bus.mem_addr2, addr);
    check({tag, "_din2"}, bus.mem_din2, wdata);
    check({tag, "_size"}, bus.mem_size, size);
    check({tag, "_sign"}, bus.mem_sign, sign);
    check({tag, "_gnt"}, bus.gnt_id, who);
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_early_ack"}, {bus.cpu_ack, bus.dbg_ack}, 0);
    @(negedge clk);
    drive_req(who, 1'b0, we, addr_late, wdata, size, sign);
    #2;
    check({tag, "_cpu_ack"}, bus.cpu_ack, !who);
    check({tag, "_dbg_ack"}, bus.dbg_ack, who);
    check({tag, "_rdata"}, who ? bus.dbg_rdata : bus.cpu_rdata, exp_rd);
    check({tag, "_other_rdata"}, who ? bus.cpu_rdata : bus.dbg_rdata, 0);
    check({tag, "_resp_strobes"}, {bus.mem_we2, bus.mem_rden2}, 0);
  endtask

  // Random-phase reference state: a transaction is just "who/what, and how many cycles since grant".
  int          age;
  bit          m_who, m_we, m_sign, m_last;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [1:0]  m_size;
  bit          pend [2];
  bit          r_we [2];
  bit          r_sign [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  logic [1:0]  r_size [2];

  task automatic model_reset();
    age = 0; m_who = 0; m_we = 0; m_sign = 0; m_last = 1;
    m_addr = 0; m_wdata = 0; m_size = 0; m_rd = 0;
  endtask

  task automatic new_fields(input int r);
    r_we[r]    = 1'($urandom_range(0, 1));
    r_addr[r]  = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
    r_wdata[r] = $urandom;
    r_size[r]  = 2'($urandom_range(0, 3));
    r_sign[r]  = 1'($urandom_range(0, 1));
  endtask

  int q_order[$];
  bit rr_en;
  bit rst_now, exp_issue, exp_resp, w;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    clear_inputs();
    tb_mem[32'h0000_6000] = 32'hDEAD_BEEF;

    do_reset();
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", bus.gnt_id, 0);
    check("rst_acks", {bus.cpu_ack, bus.dbg_ack}, 0);
    check("rst_rdata", bus.cpu_rdata | bus.dbg_rdata, 0);
    check("rst_strobes", {bus.mem_we2, bus.mem_rden2}, 0);
    check("rst_mem_outs", bus.mem_addr2 | bus.mem_din2 | {29'h0, bus.mem_size, bus.mem_sign}, 0);

    do_txn(1'b0, 1'b0, 32'h0000_6000, 32'h0, 2'd2, 1'b0, 32'h0000_6000, 32'hDEAD_BEEF, "cpu_rd");
    do_txn(1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 2'd2, 1'b0, 32'h0000_0100, 32'h0, "dbg_wr");
    do_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b1, 32'h0000_0100, 32'h1234_5678, "rd_back");
    do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 2'd0, 1'b1, 32'h0000_0020, fill_val(32'h10), "late_addr");

    // Simultaneous requests held through four transactions.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
    drive_req(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      if (bus.cpu_ack || bus.dbg_ack) begin
        q_order.push_back(int'(bus.dbg_ack));
        check("contend_one_hot", bus.cpu_ack & bus.dbg_ack, 0);
      end
    end
    check("contend_count", q_order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q_order.size())
        check($sformatf("contend_order%0d", i), q_order[i], rr_en ? (i % 2) : 0);
    @(negedge clk);
    clear_inputs();

    // Reset landing on the ISSUE cycle of a write.
    do_reset();
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 2'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #2;
    check("abort_we2", bus.mem_we2, 0);
    check("abort_rden2", bus.mem_rden2, 0);
    check("abort_acks", {bus.cpu_ack, bus.dbg_ack}, 0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("abort_busy", bus.busy, 0);
    check("abort_acks2", {bus.cpu_ack, bus.dbg_ack}, 0);
    @(negedge clk);
    #2;
    check("abort_acks3", {bus.cpu_ack, bus.dbg_ack}, 0);
    check("abort_no_write", tb_mem.exists(32'h200), 0);

    // Ten idle cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #2;
      check("idle_busy", bus.busy, 0);
      check("idle_strobes", {bus.mem_we2, bus.mem_rden2}, 0);
      check("idle_acks", {bus.cpu_ack, bus.dbg_ack}, 0);
    end

    // Randomized traffic against the transaction-level reference.
    do_reset();
    model_reset();
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_now = ($urandom_range(0, 149) == 0);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 1) == 1) begin pend[r] = 1; new_fields(r); end
        end else if ($urandom_range(0, 3) == 0) begin
          new_fields(r);
        end
        drive_req(r[0], pend[r], r_we[r], r_addr[r], r_wdata[r], r_size[r], r_sign[r]);
      end
      rst = rst_now;
      #2;
      exp_issue = (age == 1) && !rst_now;
      exp_resp  = (age == 2) && !rst_now;
      check("rnd_rden2", bus.mem_rden2, exp_issue && !m_we);
      check("rnd_we2", bus.mem_we2, exp_issue && m_we);
      check("rnd_addr2", bus.mem_addr2, m_addr);
      check("rnd_din2", bus.mem_din2, m_wdata);
      check("rnd_size", bus.mem_size, m_size);
      check("rnd_sign", bus.mem_sign, m_sign);
      check("rnd_busy", bus.busy, age != 0);
      check("rnd_gnt", bus.gnt_id, m_who);
      check("rnd_cpu_ack", bus.cpu_ack, exp_resp && !m_who);
      check("rnd_dbg_ack", bus.dbg_ack, exp_resp && m_who);
      check("rnd_cpu_rdata", bus.cpu_rdata, (exp_resp && !m_who && !m_we) ? m_rd : 32'h0);
      check("rnd_dbg_rdata", bus.dbg_rdata, (exp_resp && m_who && !m_we) ? m_rd : 32'h0);
      if (exp_resp) pend[m_who] = 0;
      if (rst_now) begin
        model_reset();
      end else if (age == 0) begin
        if (bus.cpu_req || bus.dbg_req) begin
          if (bus.cpu_req && bus.dbg_req) w = rr_en ? !m_last : 1'b0;
          else                            w = bus.dbg_req;
          m_who = w; m_last = w;
          m_we = r_we[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w];
          m_size = r_size[w]; m_sign = r_sign[w];
          age = 1;
        end
      end else if (age == 1) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_rd = ref_rd(m_addr);
        age = 2;
      end else begin
        age = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have no parameters: data and address are fixed at 32 bits, with 2 requesters (0 = cpu, 1 = dbg).
REQ-002 The block SHALL provide these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req, dbg_req  in  1 each  request, level-sensitive; held until ack.
- cpu_we, dbg_we  in  1 each  1 = write, 0 = read.
- cpu_addr, dbg_addr  in  32 each  byte address.
- cpu_wdata, dbg_wdata  in  32 each  write data.
- cpu_size, dbg_size  in  2 each  access size, Memory encoding.
- cpu_sign, dbg_sign  in  1 each  1 = unsigned load.
- cpu_ack, dbg_ack  out  1 each  one-cycle completion pulse.
- cpu_rdata, dbg_rdata  out  32 each  read data, valid while the matching ack is 1.
- mem_rden2, mem_we2  out  1 each  Memory port-2 strobes.
- mem_addr2, mem_din2  out  32 each  Memory port-2 address and write data.
- mem_size  out  2  access size.
- mem_sign  out  1  load sign control.
- mem_dout2  in  32  Memory read data, 1 cycle after mem_rden2.
- busy  out  1  1 when state is not IDLE.
- gnt_id  out  1  requester that owns the current transaction.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE, RESP.
REQ-004 In IDLE, if any req=1, the block SHALL select a winner, latch its we/addr/wdata/size/sign into internal registers, set gnt_id, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-005 In ISSUE, the block SHALL drive mem_addr2, mem_din2, mem_size and mem_sign from the latched registers, and assert mem_we2 if we=1, else mem_rden2, for exactly one cycle; then go to RESP.
REQ-006 In RESP, the block SHALL pulse the winner's ack for one cycle, place mem_dout2 on the winner's rdata (zero for writes and for the non-winner), then go to IDLE.
REQ-007 Latency SHALL be: request sampled in IDLE at cycle N, Memory access at N+1, ack at N+2; a back-to-back request re-sampled at N+3 gives 3 cycles per transaction.
REQ-008 Requests SHALL be ignored in ISSUE and RESP.
- A req still high in the IDLE cycle after ack starts a new transaction.
- Requester input changes after grant SHALL NOT affect the transaction in flight.
REQ-009 mem_rden2 and mem_we2 SHALL never both be 1, and SHALL be 0 outside ISSUE.
REQ-010 In IDLE and RESP, mem_addr2, mem_din2, mem_size and mem_sign SHALL hold their last driven values.
REQ-011 Arbitration is always single-grant: exactly one ack SHALL pulse per transaction.
REQ-012 When only one requester is active, it SHALL win regardless of arbitration history.

Reset
REQ-013 While rst=1, mem_rden2 and mem_we2 SHALL be forced to 0 combinationally, so a transaction in ISSUE is aborted with no memory side effect.
REQ-014 On a clock edge with rst=1, the block SHALL set:
- state=IDLE; busy=0; gnt_id=0;
- both acks=0; both rdata=0;
- all mem_* outputs=0;
- last_grant=1, so the cpu wins the first contention.
REQ-015 A transaction interrupted by reset SHALL never produce an ack; the requester re-requests.

Configuration
REQ-016 With macro ARB_ROUND_ROBIN_EN defined, on contention the block SHALL grant the requester that is not last_grant, and update last_grant on every grant.
REQ-017 With ARB_ROUND_ROBIN_EN undefined, the cpu SHALL always win on contention, and last_grant SHALL be unused (dbg can starve).

Verification
REQ-018 Single cpu read: cpu_req=1, we=0, addr=0x0000_6000, and the memory model returns 0xDEAD_BEEF -> mem_rden2=1 at N+1 with mem_addr2=0x6000; cpu_ack=1 at N+2 with cpu_rdata=0xDEAD_BEEF; dbg_ack stays 0.
REQ-019 Single dbg write: dbg_req, we=1, addr=0x0000_0100, wdata=0x1234_5678, size=2 -> mem_we2=1 for one cycle at N+1 with mem_din2=0x1234_5678; dbg_ack at N+2; a subsequent read returns 0x1234_5678.
REQ-020 Simultaneous requests held high for 4 transactions:
- with ARB_ROUND_ROBIN_EN, the grant order is cpu, dbg, cpu, dbg;
- without it, the order is cpu, cpu, cpu, cpu.
REQ-021 Input change after grant: in cycle N+1, change cpu_addr from 0x10 to 0x20 -> mem_addr2 is still 0x10.
REQ-022 Reset mid-transaction: assert rst during ISSUE of a write -> mem_we2=0 in that cycle, no ack is produced, and busy=0 on the next cycle.
REQ-023 Idle check: no requests for 10 cycles -> busy=0, mem_rden2=0 and mem_we2=0 throughout, and both acks stay 0.
